fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the 16-bit instruction register.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_timer.sv | 28 ++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StLoad,
    StErr
  } fetch_state_e;

  localparam int unsigned FetchAddrW   = 16;
  localparam int unsigned FetchInsnW   = 16;
  localparam int unsigned FetchTimeout = 16;
  localparam logic [15:0] FetchResetPc = 16'h0000;

endpackage

// File: rtl/fetch_timer.sv
// Clearable up-counter; tc flags the last cycle before a memory timeout.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// hands each fetched word to the instruction register with a one-cycle strobe.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = FetchAddrW,
  parameter int unsigned         INSN_W   = FetchInsnW,
  parameter logic [ADDR_W-1:0]   RESET_PC = FetchResetPc,
  parameter int unsigned         PC_STEP  = 1,
  parameter int unsigned         TIMEOUT  = FetchTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] insn_out,
  output logic              ld_ir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] insn_pc_q;
  logic [INSN_W-1:0] insn_q;
  logic              err_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_pc_q;

  logic timer_en;
  logic timer_clr;
  logic timer_tc;

  // Timer only runs in REQ and sits at zero otherwise, so every REQ entry starts fresh.
  assign timer_en  = (state_q == StReq);
  assign timer_clr = !timer_en;

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .en (timer_en),
    .tc (timer_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      insn_pc_q    <= '0;
      insn_q       <= '0;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else if (fetch_en) begin
            state_q <= StReq;
          end
        end

        StReq: begin
          if (imem_ack) begin
            pend_valid_q <= 1'b0;
            // A redirect arriving with the ack is the newest target and wins.
            if (redirect) begin
              pc_q    <= redirect_pc;
              state_q <= StIdle;
            end else if (pend_valid_q) begin
              pc_q    <= pend_pc_q;
              state_q <= StIdle;
            end else begin
              insn_q    <= imem_rdata;
              insn_pc_q <= pc_q;
              pc_q      <= pc_q + ADDR_W'(PC_STEP);
              state_q   <= StLoad;
            end
          end else if (timer_tc) begin
            err_q        <= 1'b1;
            pend_valid_q <= 1'b0;
            state_q      <= StErr;
          end else if (redirect) begin
            // Request cannot be withdrawn; remember the target until the ack.
            pend_valid_q <= 1'b1;
            pend_pc_q    <= redirect_pc;
          end
        end

        StLoad: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          state_q <= fetch_en ? StReq : StIdle;
        end

        StErr: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign ld_ir     = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign pc        = pc_q;
  assign insn_pc   = insn_pc_q;
  assign insn_out  = insn_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared every cycle against a transaction-level reference model.
module tb_fetch_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] insn_out;
  logic        ld_ir;
  logic [15:0] pc;
  logic [15:0] insn_pc;
  logic        busy;
  logic        fetch_err;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase 0 idle, 1 request outstanding, 2 word delivered, 3 faulted
  int          m_ph;
  int          m_cyc;
  logic [15:0] m_pc, m_insn, m_insn_pc, m_pend;
  bit          m_err, m_has_pend;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .insn_out   (insn_out),
    .ld_ir      (ld_ir),
    .pc         (pc),
    .insn_pc    (insn_pc),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cyc = 0; m_pc = 16'h0000; m_insn = '0; m_insn_pc = '0;
    m_pend = '0; m_err = 0; m_has_pend = 0;
  endtask

  task automatic model_step(input bit fe, input bit rd, input logic [15:0] rpc,
                            input bit ack, input logic [15:0] rdata);
    case (m_ph)
      0: if (rd) m_pc = rpc; else if (fe) begin m_ph = 1; m_cyc = 0; end
      1: begin
        m_cyc++;
        if (rd) begin m_has_pend = 1; m_pend = rpc; end
        if (ack) begin
          if (m_has_pend) begin
            m_pc = m_pend; m_ph = 0;
          end else begin
            m_insn = rdata; m_insn_pc = m_pc; m_pc = m_pc + 16'd1; m_ph = 2;
          end
          m_has_pend = 0;
        end else if (m_cyc == TO) begin
          m_err = 1; m_ph = 3; m_has_pend = 0;
        end
      end
      2: begin
        if (rd) m_pc = rpc;
        if (fe) begin m_ph = 1; m_cyc = 0; end else m_ph = 0;
      end
      default: if (rd) begin m_pc = rpc; m_err = 0; m_ph = 0; end
    endcase
  endtask

  task automatic check_all();
    check_eq("imem_req", imem_req, m_ph == 1);
    if (m_ph == 1) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("ld_ir", ld_ir, m_ph == 2);
    check_eq("busy", busy, m_ph != 0);
    check_eq("pc", pc, m_pc);
    check_eq("insn_out", insn_out, m_insn);
    check_eq("insn_pc", insn_pc, m_insn_pc);
    check_eq("fetch_err", fetch_err, m_err);
  endtask

  // Called just after a falling edge: drive inputs, advance the model, check at the next fall.
  task automatic step(input bit fe, input bit rd, input logic [15:0] rpc,
                      input bit ack, input logic [15:0] rdata);
    fetch_en = fe; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdata;
    model_step(fe, rd, rpc, ack, rdata);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_dut();
    fetch_en = 0; redirect = 0; imem_ack = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int ack_pct;
    model_reset();
    @(negedge clk);
    reset_dut();
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_insn", insn_out, 16'h0000);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_err", fetch_err, 1'b0);

    // Single fetch, zero-wait memory
    step(1, 0, 0, 0, 0);
    check_eq("t1_req", imem_req, 1'b1);
    step(0, 0, 0, 1, 16'h1234);
    check_eq("t1_ld_ir", ld_ir, 1'b1);
    check_eq("t1_insn", insn_out, 16'h1234);
    check_eq("t1_insn_pc", insn_pc, 16'h0000);
    check_eq("t1_pc", pc, 16'h0001);
    step(0, 0, 0, 0, 0);
    check_eq("t1_ld_ir_once", ld_ir, 1'b0);

    // fetch_en held, ack three cycles late
    reset_dut();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 3; w++) begin
        step(1, 0, 0, 0, 0);
        check_eq("t2_addr_stable", imem_addr, i);
      end
      step(1, 0, 0, 1, 16'hA000 + 16'(i));
      check_eq("t2_ld_ir", ld_ir, 1'b1);
      check_eq("t2_insn_pc", insn_pc, i);
      step(1, 0, 0, 0, 0);
    end

    // Redirect while request outstanding
    reset_dut();
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h0040, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'hDEAD);
    check_eq("t3_no_ld_ir", ld_ir, 1'b0);
    check_eq("t3_pc", pc, 16'h0040);
    check_eq("t3_idle", busy, 1'b0);
    step(1, 0, 0, 0, 0);
    check_eq("t3_next_addr", imem_addr, 16'h0040);

    // PC wrap
    reset_dut();
    step(0, 1, 16'hFFFF, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'hBEEF);
    check_eq("t4_insn_pc", insn_pc, 16'hFFFF);
    check_eq("t4_pc_wrap", pc, 16'h0000);

    // Memory timeout and recovery
    reset_dut();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
    check_eq("t5_err_early", fetch_err, 1'b0);
    check_eq("t5_req_held", imem_req, 1'b1);
    step(0, 0, 0, 0, 0);
    check_eq("t5_err", fetch_err, 1'b1);
    check_eq("t5_req_drop", imem_req, 1'b0);
    step(1, 0, 0, 1, 0);
    check_eq("t5_err_sticky", fetch_err, 1'b1);
    step(0, 1, 16'h0100, 0, 0);
    check_eq("t5_err_clr", fetch_err, 1'b0);
    check_eq("t5_idle", busy, 1'b0);
    check_eq("t5_pc", pc, 16'h0100);

    // Asynchronous reset in the middle of a request
    reset_dut();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 16'h5A5A);
    step(1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_req", imem_req, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_insn", insn_out, 16'h0000);
    check_eq("t6_pc", pc, 16'h0000);
    fetch_en = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    check_eq("t6_pc_after", pc, 16'h0000);

    // Randomized run against the model
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] rpc;
      if (c % 150 == 0) begin
        case ($urandom_range(3))
          0: ack_pct = 0;
          1: ack_pct = 20;
          2: ack_pct = 60;
          default: ack_pct = 100;
        endcase
      end
      rpc = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(99) < 60, $urandom_range(99) < 8, rpc,
           $urandom_range(99) < ack_pct, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
